// File: rtl/l2_cache_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_types_pkg
// Brief    : Shared state encoding and address-split constants for the L2 controller
// Revision : 1.0
// ============================================================================
package l2_types_pkg;

    localparam int C_ADDR_W         = 32;
    localparam int C_DEF_OFFSET     = 5;
    localparam int C_DEF_INDEX      = 3;
    localparam int C_DEF_TAG        = C_ADDR_W - C_DEF_INDEX - C_DEF_OFFSET;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TAG    = 3'd1,
        WB     = 3'd2,
        FILL   = 3'd3,
        REREAD = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/l2_cache_control_tag_array.sv
`default_nettype none
// ============================================================================
// Module   : l2_tag_array
// Brief    : Per-set tag/valid/dirty storage with combinational read
// Revision : 1.0
// ============================================================================
module l2_tag_array #(
    parameter int S_INDEX = 3,
    parameter int S_TAG   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [S_INDEX-1:0] i_index,
    input  logic               i_fill,
    input  logic [S_TAG-1:0]   i_tag,
    input  logic               i_set_dirty,
    output logic [S_TAG-1:0]   o_tag,
    output logic               o_valid,
    output logic               o_dirty
);

    localparam int C_SETS = 2**S_INDEX;

    logic [S_TAG-1:0]  r_tag [C_SETS];
    logic [C_SETS-1:0] r_valid;
    logic [C_SETS-1:0] r_dirty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_set_dirty) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    // Tags are never cleared; a cleared valid bit masks stale contents.
    always_ff @(posedge clk) begin
        if (rst_n && i_fill) begin
            r_tag[i_index] <= i_tag;
        end
    end

    assign o_tag   = r_tag[i_index];
    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];

endmodule
`default_nettype wire

// File: rtl/l2_cache_control.sv
`default_nettype none
// ============================================================================
// Module   : l2_cache_control
// Brief    : Direct-mapped L2 sequencer: hit service, writeback, fill, reread
// Revision : 1.0
// ============================================================================
module l2_cache_control
    import l2_types_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_mask   = 2**s_offset,
    parameter int s_line   = 8*s_mask,
    parameter int s_tag    = 32-s_index-s_offset
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        mem_address,
    input  logic [s_line-1:0]  mem_wdata,
    input  logic [s_mask-1:0]  mem_wmask,
    output logic [s_line-1:0]  mem_rdata,
    output logic               mem_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    output logic [s_line-1:0]  pmem_wdata,
    input  logic [s_line-1:0]  pmem_rdata,
    input  logic               pmem_resp,
    output logic               data_read,
    output logic [s_mask-1:0]  data_write_en,
    output logic [s_index-1:0] data_index,
    output logic [s_line-1:0]  data_datain,
    input  logic [s_line-1:0]  data_dataout
);

    state_t             r_state;
    state_t             w_next;
    logic [31:s_offset] r_line_addr;
    logic               r_is_write;

    logic [s_tag-1:0]   w_tag;
    logic [s_index-1:0] w_index;
    logic [s_tag-1:0]   w_old_tag;
    logic               w_valid;
    logic               w_dirty;
    logic               w_hit;
    logic               w_req;
    logic               w_fill;
    logic               w_set_dirty;
    logic               w_unused_offset;

    assign w_tag           = r_line_addr[31 -: s_tag];
    assign w_index         = r_line_addr[s_offset +: s_index];
    assign w_hit           = w_valid && (w_old_tag == w_tag);
    assign w_req           = mem_read | mem_write;
    assign w_unused_offset = ^mem_address[s_offset-1:0];

    assign mem_rdata  = data_dataout;
    assign pmem_wdata = data_dataout;

    l2_tag_array #(
        .S_INDEX (s_index),
        .S_TAG   (s_tag)
    ) u_tag_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_index     (w_index),
        .i_fill      (w_fill),
        .i_tag       (w_tag),
        .i_set_dirty (w_set_dirty),
        .o_tag       (w_old_tag),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && (r_state == IDLE) && w_req) begin
            r_line_addr <= mem_address[31:s_offset];
            r_is_write  <= mem_write;
        end
    end

    always_comb begin
        w_next        = r_state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_address  = {w_tag, w_index, {s_offset{1'b0}}};
        data_read     = 1'b0;
        data_write_en = '0;
        data_index    = w_index;
        data_datain   = pmem_rdata;
        w_fill        = 1'b0;
        w_set_dirty   = 1'b0;

        case (r_state)
            IDLE: begin
                // The array must see the incoming index on the launching edge.
                data_index = mem_address[s_offset +: s_index];
                if (rst_n && w_req) begin
                    data_read = 1'b1;
                    w_next    = TAG;
                end
            end
            TAG: begin
                if (w_hit) begin
                    mem_resp = 1'b1;
                    w_next   = IDLE;
                    if (r_is_write) begin
                        data_write_en = mem_wmask;
                        data_datain   = mem_wdata;
                        w_set_dirty   = 1'b1;
                    end
                end else if (w_valid && w_dirty) begin
                    w_next = WB;
                end else begin
                    w_next = FILL;
                end
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {w_old_tag, w_index, {s_offset{1'b0}}};
                if (pmem_resp) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_write_en = '1;
                    w_fill        = 1'b1;
                    w_next        = REREAD;
                end
            end
            REREAD: begin
                data_read = 1'b1;
                w_next    = TAG;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_cache_control
// Brief    : Directed scoreboard bench with data-array and pmem behavioural models
// Revision : 1.0
// ============================================================================
module tb_l2_cache_control;

    localparam int C_LAT = 3;

    typedef struct {
        bit           chk;
        logic [255:0] data;
    } rd_exp_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } pm_exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_wmask;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         data_read;
    logic [31:0]  data_write_en;
    logic [2:0]   data_index;
    logic [255:0] data_datain;
    logic [255:0] data_dataout;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pcnt     = 0;
    bit ignore_pmem = 1'b0;

    rd_exp_t rd_q[$];
    pm_exp_t pm_q[$];

    logic [255:0] darr [8];
    logic [255:0] pmem_mem [logic [31:0]];

    logic [255:0] line_a, line_b, line_c, line_d, line_e, line_f, line_g, line_m, line_cg;

    l2_cache_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rdata     (mem_rdata),
        .mem_resp      (mem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .data_read     (data_read),
        .data_write_en (data_write_en),
        .data_index    (data_index),
        .data_datain   (data_datain),
        .data_dataout  (data_dataout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data array: registered read returns the pre-write line on a same-edge write.
    always @(posedge clk) begin
        if (data_read) data_dataout <= darr[data_index];
        for (int b = 0; b < 32; b++) begin
            if (data_write_en[b]) darr[data_index][b*8 +: 8] <= data_datain[b*8 +: 8];
        end
    end

    // Physical memory: responds C_LAT cycles after a request first appears.
    always @(posedge clk) begin
        if (!rst_n) begin
            pmem_resp <= 1'b0;
            pcnt      <= 0;
        end else if (pmem_resp) begin
            pmem_resp <= 1'b0;
            pcnt      <= 0;
        end else if (pmem_read || pmem_write) begin
            if (pcnt == C_LAT - 1) begin
                pmem_resp <= 1'b1;
                pcnt      <= 0;
                if (pmem_write) pmem_mem[pmem_address] = pmem_wdata;
                else            pmem_rdata <= pmem_mem[pmem_address];
            end else begin
                pcnt <= pcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] merge(input logic [255:0] old_l, input logic [255:0] new_l,
                                           input logic [31:0] mask);
        logic [255:0] r;
        r = old_l;
        for (int b = 0; b < 32; b++) if (mask[b]) r[b*8 +: 8] = new_l[b*8 +: 8];
        return r;
    endfunction

    // pmem transaction scoreboard
    always @(negedge clk) begin
        pm_exp_t e;
        if (rst_n && !ignore_pmem && (pmem_read || pmem_write)) begin
            chk("pmem_exclusive", {255'b0, pmem_read & pmem_write}, 256'd0);
            if (pm_q.size() == 0) begin
                chk("pmem_unexpected", {254'b0, pmem_read, pmem_write}, 256'd0);
            end else if (pmem_resp) begin
                e = pm_q.pop_front();
                chk("pmem_kind", {255'b0, pmem_write}, {255'b0, e.wr});
                chk("pmem_addr", {224'b0, pmem_address}, {224'b0, e.addr});
                if (e.wr) chk("pmem_wdata", pmem_wdata, e.data);
            end
        end
    end

    task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [255:0] wd, input logic [31:0] wm, input int exp_lat,
                          input string tag);
        int      start;
        rd_exp_t e;
        @(posedge clk);
        #1;
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        mem_wdata   = wd;
        mem_wmask   = wm;
        start       = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_resp) break;
        end
        chk({tag, "_resp"}, {255'b0, mem_resp}, 256'd1);
        if (mem_resp === 1'b1 && rd_q.size() > 0) begin
            e = rd_q.pop_front();
            if (e.chk) chk({tag, "_rdata"}, mem_rdata, e.data);
            chk({tag, "_latency"}, 256'(cyc - start), 256'(exp_lat));
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        line_a  = {4{64'hA0A1_A2A3_A4A5_A6A7}};
        line_b  = {4{64'hB0B1_B2B3_B4B5_B6B7}};
        line_c  = {4{64'hC0C1_C2C3_C4C5_C6C7}};
        line_d  = {4{64'hD0D1_D2D3_D4D5_D6D7}};
        line_e  = {4{64'hE0E1_E2E3_E4E5_E6E7}};
        line_f  = {4{64'hF0F1_F2F3_F4F5_F6F7}};
        line_g  = {4{64'h1011_1213_1415_1617}};
        line_m  = merge(line_a, line_b, 32'h0000_000F);
        line_cg = merge(line_c, line_g, 32'h0000_FF00);
        pmem_mem[32'h0000_1040] = line_a;
        pmem_mem[32'h0000_2040] = line_c;
        pmem_mem[32'h0000_3060] = line_d;
        pmem_mem[32'h0000_4060] = line_f;
        pmem_mem[32'h0000_4000] = line_g;

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata = '0; mem_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_resp",   {255'b0, mem_resp},   256'd0);
        chk("rst_pmem_read",  {255'b0, pmem_read},  256'd0);
        chk("rst_pmem_write", {255'b0, pmem_write}, 256'd0);
        chk("rst_data_read",  {255'b0, data_read},  256'd0);
        chk("rst_data_we",    {224'b0, data_write_en}, 256'd0);
        rst_n = 1'b1;

        // Clean miss, then hit on the same line
        pm_q.push_back('{0, 32'h0000_1040, '0});
        rd_q.push_back('{1, line_a});
        do_req(0, 1, 32'h0000_1040, '0, '0, 4 + C_LAT, "rd_miss_1040");
        rd_q.push_back('{1, line_a});
        do_req(0, 1, 32'h0000_1040, '0, '0, 1, "rd_hit_1040");

        // Partial write hit, read back the merged line
        rd_q.push_back('{0, '0});
        do_req(1, 0, 32'h0000_1040, line_b, 32'h0000_000F, 1, "wr_hit_1040");
        rd_q.push_back('{1, line_m});
        do_req(0, 1, 32'h0000_1040, '0, '0, 1, "rd_merged_1040");

        // Conflict on set 2 forces a writeback of the merged line
        pm_q.push_back('{1, 32'h0000_1040, line_m});
        pm_q.push_back('{0, 32'h0000_2040, '0});
        rd_q.push_back('{1, line_c});
        do_req(0, 1, 32'h0000_2040, '0, '0, 5 + 2*C_LAT, "rd_dirty_2040");

        // Full-line write miss, then evict it to expose the dirty bit
        pm_q.push_back('{0, 32'h0000_3060, '0});
        rd_q.push_back('{0, '0});
        do_req(1, 0, 32'h0000_3060, line_e, 32'hFFFF_FFFF, 4 + C_LAT, "wr_miss_3060");
        rd_q.push_back('{1, line_e});
        do_req(0, 1, 32'h0000_3060, '0, '0, 1, "rd_hit_3060");
        pm_q.push_back('{1, 32'h0000_3060, line_e});
        pm_q.push_back('{0, 32'h0000_4060, '0});
        rd_q.push_back('{1, line_f});
        do_req(0, 1, 32'h0000_4060, '0, '0, 5 + 2*C_LAT, "rd_dirty_4060");

        // Reset while a fill is outstanding
        ignore_pmem = 1'b1;
        @(posedge clk);
        #1;
        mem_read    = 1'b1;
        mem_address = 32'h0000_4000;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pmem_read) break;
        end
        chk("rstfill_reached", {255'b0, pmem_read}, 256'd1);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        chk("rstfill_mem_resp",   {255'b0, mem_resp},   256'd0);
        chk("rstfill_pmem_read",  {255'b0, pmem_read},  256'd0);
        chk("rstfill_pmem_write", {255'b0, pmem_write}, 256'd0);
        chk("rstfill_data_read",  {255'b0, data_read},  256'd0);
        chk("rstfill_data_we",    {224'b0, data_write_en}, 256'd0);
        rst_n       = 1'b1;
        ignore_pmem = 1'b0;

        pm_q.push_back('{0, 32'h0000_2040, '0});
        rd_q.push_back('{1, line_c});
        do_req(0, 1, 32'h0000_2040, '0, '0, 4 + C_LAT, "rd_after_rst_2040");

        // Simultaneous read and write: the write must take effect
        rd_q.push_back('{0, '0});
        do_req(1, 1, 32'h0000_2040, line_g, 32'h0000_FF00, 1, "rdwr_2040");
        rd_q.push_back('{1, line_cg});
        do_req(0, 1, 32'h0000_2040, '0, '0, 1, "rd_after_rdwr_2040");

        repeat (2) @(posedge clk);
        chk("pm_q_drained", 256'(pm_q.size()), 256'd0);
        chk("rd_q_drained", 256'(rd_q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
